// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART 8N1 receiver with mid-bit sampling, framing/overrun flags and a small byte FIFO.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int CW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] LAST   = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF   = CW'(CPB / 2 - 1);
    localparam logic [NW-1:0] FULL_N = NW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t          state, state_nx;
    logic            rx_m, rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            cnt_clr, shift_en, push, ferr, stop_ok;
`ifdef UART_RX_PARITY_EN
    logic            par_en, par_bad;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            pop, full, wr_en;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

`ifdef UART_RX_PARITY_EN
    assign stop_ok = rx_s & !par_bad;
`else
    assign stop_ok = rx_s;
`endif

    // Next-state and per-cycle control: sample points, push request, framing error.
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        push     = 1'b0;
        ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s)
                    state_nx = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_clr  = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    state_nx = (bit_idx == 3'd7) ? PARITY : DATA;
`else
                    state_nx = (bit_idx == 3'd7) ? STOP : DATA;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    par_en   = 1'b1;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    push     = stop_ok;
                    ferr     = !stop_ok;
                    state_nx = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_clr = 1'b1;
                if (rx_s)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bit-period counter, shift register and data bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            cnt <= (cnt_clr || cnt == LAST) ? '0 : cnt + 1'b1;
            if (shift_en) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity check: data ones plus parity bit must be even.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_bad <= 1'b0;
        else if (par_en)
            par_bad <= ^shift ^ rx_s;
    end
`endif

    assign pop        = data_valid & data_ready;
    assign full       = count == FULL_N;
    assign wr_en      = push & (!full | pop);
    assign data_valid = count != '0;
    assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;
    assign busy       = state != IDLE;

    // FIFO storage; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= shift;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (!wr_en && pop)
                count <= count - 1'b1;
        end
    end

    // Registered one-cycle error pulses; a push and a framing error never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= push & full & !pop;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 16 clocks per bit, depth 4.
module tb_uart_rx_fifo;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 156 + PB * CPB;

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;
    logic       par_flip = 1'b0;

    int         pass_n = 0, total_n = 0;
    logic [7:0] got [256];
    int         got_n = 0, ferr_n = 0, ovr_n = 0, both_n = 0, rd_i = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Capture accepted bytes and error pulses away from the active edge.
    always @(negedge clk) begin
        if (data_valid && data_ready && got_n < 256) begin
            got[got_n] = data_out;
            got_n++;
        end
        if (frame_err) ferr_n++;
        if (overrun) ovr_n++;
        if (frame_err && overrun) both_n++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 1000000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d ^ par_flip;
        repeat (CPB) tick();
`endif
        rx = stop_b;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic drain;
        data_ready = 1'b1;
        for (int i = 0; i < 100 && data_valid; i++) tick();
        tick();
        data_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total_n += 5;
        if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else pass_n++;
        if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else pass_n++;
        if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_n++;
        if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else pass_n++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_n++;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_first_byte;
        int idx = 0;
        int f0 = ferr_n, o0 = ovr_n;
        logic [7:0] e;
        data_ready = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 400; i++) begin
                    @(negedge clk);
                    if (data_valid) begin
                        idx = i;
                        break;
                    end
                end
            end
        join
        repeat (20) tick();
        data_ready = 1'b0;
        total_n += 4;
        if (idx != LAT) $display("FAIL a5_latency: valid at clk %0d want %0d", idx, LAT); else pass_n++;
        if (ferr_n != f0 || ovr_n != o0) $display("FAIL a5_flags: ferr %0d ovr %0d want 0 0", ferr_n - f0, ovr_n - o0); else pass_n++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_n++;
            if (rd_i >= got_n || got[rd_i] !== e) $display("FAIL a5_byte: got %h want %h", rd_i < got_n ? got[rd_i] : 8'hxx, e); else pass_n++;
            rd_i++;
        end
        if (got_n != rd_i) $display("FAIL a5_count: got %0d bytes want %0d", got_n, rd_i); else pass_n++;
        if (data_valid !== 1'b0) $display("FAIL a5_popped: valid %b want 0", data_valid); else pass_n++;
    endtask

    task automatic test_glitch;
        int f0 = ferr_n, g0 = got_n;
        logic b_mid;
        rx = 1'b0;
        repeat (4) tick();
        b_mid = busy;
        repeat (2) tick();
        rx = 1'b1;
        repeat (30) tick();
        total_n += 4;
        if (b_mid !== 1'b1) $display("FAIL glitch_busy_mid: got %b want 1", b_mid); else pass_n++;
        if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else pass_n++;
        if (ferr_n != f0) $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_n - f0); else pass_n++;
        if (got_n != g0 || data_valid !== 1'b0) $display("FAIL glitch_byte: got %0d bytes valid %b want 0 0", got_n - g0, data_valid); else pass_n++;
    endtask

    task automatic test_frame_err;
        int f0 = ferr_n, g0 = got_n;
        logic b_brk;
        logic [7:0] e;
        data_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) tick();
        b_brk = busy;
        rx = 1'b1;
        repeat (30) tick();
        total_n += 4;
        if (ferr_n - f0 != 1) $display("FAIL ferr_pulses: got %0d want 1", ferr_n - f0); else pass_n++;
        if (got_n != g0 || data_valid !== 1'b0) $display("FAIL ferr_empty: got %0d bytes valid %b want 0 0", got_n - g0, data_valid); else pass_n++;
        if (b_brk !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", b_brk); else pass_n++;
        if (busy !== 1'b0) $display("FAIL ferr_busy_idle: got %b want 0", busy); else pass_n++;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (20) tick();
        data_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_n++;
            if (rd_i >= got_n || got[rd_i] !== e) $display("FAIL ferr_next_byte: got %h want %h", rd_i < got_n ? got[rd_i] : 8'hxx, e); else pass_n++;
            rd_i++;
        end
    endtask

    task automatic test_overrun;
        int o0 = ovr_n, g0 = got_n;
        logic [7:0] e;
        data_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b1);
        end
        repeat (20) tick();
        total_n += 3;
        if (ovr_n - o0 != 1) $display("FAIL ovr_pulses: got %0d want 1", ovr_n - o0); else pass_n++;
        if (got_n != g0) $display("FAIL ovr_no_pop: got %0d bytes want 0", got_n - g0); else pass_n++;
        if (data_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", data_valid); else pass_n++;
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_n++;
            if (rd_i >= got_n || got[rd_i] !== e) $display("FAIL ovr_order: got %h want %h", rd_i < got_n ? got[rd_i] : 8'hxx, e); else pass_n++;
            rd_i++;
        end
        total_n += 2;
        if (got_n != rd_i) $display("FAIL ovr_count: got %0d bytes want %0d", got_n, rd_i); else pass_n++;
        if (data_valid !== 1'b0) $display("FAIL ovr_drained: valid %b want 0", data_valid); else pass_n++;
    endtask

    task automatic test_full_pop;
        int o0;
        logic [7:0] e;
        data_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'h21 + 8'(k));
            send_frame(8'h21 + 8'(k), 1'b1);
        end
        o0 = ovr_n;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (LAT - 2) tick();
                data_ready = 1'b1;
                tick();
                data_ready = 1'b0;
            end
        join
        repeat (20) tick();
        total_n += 2;
        if (ovr_n != o0) $display("FAIL full_pop_ovr: got %0d pulses want 0", ovr_n - o0); else pass_n++;
        if (data_valid !== 1'b1) $display("FAIL full_pop_valid: got %b want 1", data_valid); else pass_n++;
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_n++;
            if (rd_i >= got_n || got[rd_i] !== e) $display("FAIL full_pop_order: got %h want %h", rd_i < got_n ? got[rd_i] : 8'hxx, e); else pass_n++;
            rd_i++;
        end
        total_n++;
        if (got_n != rd_i) $display("FAIL full_pop_count: got %0d bytes want %0d", got_n, rd_i); else pass_n++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int f0 = ferr_n, g0 = got_n;
        logic [7:0] e;
        data_ready = 1'b1;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (20) tick();
        total_n += 3;
        if (ferr_n - f0 != 1) $display("FAIL par_bad_ferr: got %0d pulses want 1", ferr_n - f0); else pass_n++;
        if (got_n != g0) $display("FAIL par_bad_push: got %0d bytes want 0", got_n - g0); else pass_n++;
        if (busy !== 1'b0) $display("FAIL par_bad_idle: busy %b want 0", busy); else pass_n++;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        repeat (20) tick();
        data_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_n++;
            if (rd_i >= got_n || got[rd_i] !== e) $display("FAIL par_good_byte: got %h want %h", rd_i < got_n ? got[rd_i] : 8'hxx, e); else pass_n++;
            rd_i++;
        end
        total_n++;
        if (ferr_n - f0 != 1) $display("FAIL par_good_ferr: got %0d pulses want 1", ferr_n - f0); else pass_n++;
    endtask
`endif

    initial begin
        test_reset();
        test_first_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        total_n++;
        if (both_n != 0) $display("FAIL flags_exclusive: %0d cycles with both high want 0", both_n); else pass_n++;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
